dcache_controller: RTL and testbench

- Responder side of the memory-stage request interface: consumes RegWrite-free MEM-stage requests (MemRead/MemWrite, address, store data) held by the EX/MEM pipeline register.
- Generates the MemStall signal that freezes the pipeline registers during misses.
- Direct-mapped, write-back, write-allocate L1 data cache in front of a multi-cycle 256-bit data memory with a level request/ack handshake.

---
 rtl/dcache_controller_pkg.sv | 19 +
 rtl/dcache_controller_sram.sv | 56 +++++
 rtl/dcache_controller.sv | 150 +++++++++++++++
 tb/tb_dcache_controller.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_controller_pkg.sv
// Shared definitions for the L1 data cache controller.
// This package holds the address field widths, the line size and the miss-handling FSM encoding.
package dcache_controller_pkg;

    localparam int LINES     = 16;
    localparam int INDEX_W   = 4;
    localparam int OFFSET_W  = 5;
    localparam int TAG_W     = 32 - INDEX_W - OFFSET_W;
    localparam int LINE_BITS = 256;
    localparam int WORD_W    = 3;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WRITEBACK  = 2'd1,
        ST_READMISS   = 2'd2,
        ST_READMISSOK = 2'd3
    } state_t;

endpackage

// File: rtl/dcache_controller_sram.sv
// Tag/valid/dirty/data storage for the direct-mapped cache: asynchronous read,
// synchronous full-line fill and single-word store writes.
module dcache_sram
    import dcache_controller_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [INDEX_W-1:0]   i_index,
    input  logic [WORD_W-1:0]    i_word,
    output logic [TAG_W-1:0]     o_tag,
    output logic                 o_valid,
    output logic                 o_dirty,
    output logic [LINE_BITS-1:0] o_line,
    input  logic                 i_line_we,
    input  logic [TAG_W-1:0]     i_line_tag,
    input  logic [LINE_BITS-1:0] i_line_data,
    input  logic                 i_word_we,
    input  logic [31:0]          i_word_data
);

    logic [LINES-1:0]     r_valid;
    logic [LINES-1:0]     r_dirty;
    logic [TAG_W-1:0]     r_tag  [LINES];
    logic [LINE_BITS-1:0] r_data [LINES];
    logic [7:0]           w_bit_base;

    assign w_bit_base = {i_word, 5'b0};

    assign o_tag   = r_tag[i_index];
    assign o_valid = r_valid[i_index];
    assign o_dirty = r_dirty[i_index];
    assign o_line  = r_data[i_index];

    // A fill always leaves the line clean; a store hit marks it dirty.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_line_we) begin
            r_valid[i_index] <= 1'b1;
            r_dirty[i_index] <= 1'b0;
        end else if (i_word_we) begin
            r_dirty[i_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (i_line_we) begin
            r_tag[i_index]  <= i_line_tag;
            r_data[i_index] <= i_line_data;
        end else if (i_word_we) begin
            r_data[i_index][w_bit_base +: 32] <= i_word_data;
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate L1 data cache controller.
// It decides hit/miss, drives MemStall, and sequences write-back and fill against the line memory.
module dcache_controller
    import dcache_controller_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cpu_MemRead_i,
    input  logic                 cpu_MemWrite_i,
    input  logic [31:0]          cpu_addr_i,
    input  logic [31:0]          cpu_data_i,
    output logic [31:0]          cpu_data_o,
    output logic                 cpu_stall_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o,
    output logic [31:0]          mem_addr_o,
    output logic [LINE_BITS-1:0] mem_data_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i
);

    state_t               r_state;
    state_t               w_next_state;
    logic                 r_mem_enable;
    logic                 r_mem_write;
    logic [31:0]          r_mem_addr;
    logic [LINE_BITS-1:0] r_mem_data;

    logic [TAG_W-1:0]     w_tag;
    logic [INDEX_W-1:0]   w_index;
    logic [WORD_W-1:0]    w_word;
    logic [7:0]           w_bit_base;
    logic [TAG_W-1:0]     w_line_tag;
    logic                 w_line_valid;
    logic                 w_line_dirty;
    logic [LINE_BITS-1:0] w_line;
    logic                 w_req;
    logic                 w_hit;
    logic                 w_miss_start;
    logic                 w_write_hit;
    logic                 w_fill;
    logic                 w_unused_addr;

    assign w_tag         = cpu_addr_i[31:32-TAG_W];
    assign w_index       = cpu_addr_i[OFFSET_W +: INDEX_W];
    assign w_word        = cpu_addr_i[4:2];
    assign w_bit_base    = {w_word, 5'b0};
    assign w_unused_addr = ^cpu_addr_i[1:0];

    assign w_req        = cpu_MemRead_i || cpu_MemWrite_i;
    assign w_hit        = w_line_valid && (w_line_tag == w_tag);
    assign w_miss_start = (r_state == ST_IDLE) && w_req && !w_hit;
    assign w_write_hit  = (r_state == ST_IDLE) && cpu_MemWrite_i && w_hit;
    assign w_fill       = (r_state == ST_READMISS) && mem_ack_i;

    assign cpu_stall_o  = (w_req && !w_hit) || (r_state != ST_IDLE);
    assign cpu_data_o   = (cpu_MemRead_i && w_hit) ? w_line[w_bit_base +: 32] : 32'h0;

    assign mem_enable_o = r_mem_enable;
    assign mem_write_o  = r_mem_write;
    assign mem_addr_o   = r_mem_addr;
    assign mem_data_o   = r_mem_data;

    dcache_sram u_sram (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .i_index     (w_index),
        .i_word      (w_word),
        .o_tag       (w_line_tag),
        .o_valid     (w_line_valid),
        .o_dirty     (w_line_dirty),
        .o_line      (w_line),
        .i_line_we   (w_fill),
        .i_line_tag  (w_tag),
        .i_line_data (mem_data_i),
        .i_word_we   (w_write_hit),
        .i_word_data (cpu_data_i)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_req && !w_hit) begin
                    w_next_state = w_line_dirty ? ST_WRITEBACK : ST_READMISS;
                end
            end
            ST_WRITEBACK: begin
                if (mem_ack_i) begin
                    w_next_state = ST_READMISS;
                end
            end
            ST_READMISS: begin
                if (mem_ack_i) begin
                    w_next_state = ST_READMISSOK;
                end
            end
            ST_READMISSOK: w_next_state = ST_IDLE;
            default:       w_next_state = ST_IDLE;
        endcase
    end

    // Memory-side outputs are loaded on state transitions so they never follow the CPU inputs combinationally.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_mem_enable <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= 32'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_miss_start) begin
                        r_mem_enable <= 1'b1;
                        r_mem_write  <= w_line_dirty;
                        r_mem_addr   <= w_line_dirty ? {w_line_tag, w_index, 5'b0}
                                                     : {w_tag, w_index, 5'b0};
                    end
                end
                ST_WRITEBACK: begin
                    if (mem_ack_i) begin
                        r_mem_write <= 1'b0;
                        r_mem_addr  <= {w_tag, w_index, 5'b0};
                    end
                end
                ST_READMISS: begin
                    if (mem_ack_i) begin
                        r_mem_enable <= 1'b0;
                        r_mem_addr   <= 32'h0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_miss_start) begin
            r_mem_data <= w_line;
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: a line-granular cache/memory model predicts
// stall length, load data and every memory transaction; a responder plays the line memory.
module tb_dcache_controller;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         cpu_MemRead_i;
    logic         cpu_MemWrite_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_data_i;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;

    dcache_controller dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .cpu_MemRead_i  (cpu_MemRead_i),
        .cpu_MemWrite_i (cpu_MemWrite_i),
        .cpu_addr_i     (cpu_addr_i),
        .cpu_data_i     (cpu_data_i),
        .cpu_data_o     (cpu_data_o),
        .cpu_stall_o    (cpu_stall_o),
        .mem_enable_o   (mem_enable_o),
        .mem_write_o    (mem_write_o),
        .mem_addr_o     (mem_addr_o),
        .mem_data_o     (mem_data_o),
        .mem_data_i     (mem_data_i),
        .mem_ack_i      (mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit           isWrite;
        logic [31:0]  addr;
        logic [255:0] data;
        int           lat;
    } memTxn_t;

    memTxn_t      expQ[$];
    bit           mValid [16];
    bit           mDirty [16];
    logic [22:0]  mTag   [16];
    logic [255:0] mLine  [16];
    logic [255:0] memArr [logic [31:0]];

    int           nChecks = 0;
    int           nPass   = 0;
    int           lastStall;
    logic [31:0]  lastData;
    logic [31:0]  lastWbAddr;
    logic [255:0] lastWbData;
    bit           respEnable = 1'b1;
    bit           spurOn = 1'b0;
    bit           busy = 1'b0;
    bit           wasAck;
    int           cnt;
    memTxn_t      cur;

    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        nChecks++;
        if (actual === expected) nPass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    function automatic logic [255:0] memLine(input logic [31:0] la);
        logic [255:0] l;
        if (memArr.exists(la)) return memArr[la];
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = (la + 32'(i * 4)) ^ 32'hC0DE0000;
        return l;
    endfunction

    task automatic resetModel();
        for (int i = 0; i < 16; i++) begin
            mValid[i] = 1'b0;
            mDirty[i] = 1'b0;
        end
    endtask

    // Called just after a rising edge; returns just after the edge that consumes the request.
    task automatic applyStimulus(input bit isWrite, input logic [31:0] addr, input logic [31:0] data,
                                 input int fillLat, input int wbLat);
        int          idx = int'(addr[8:5]);
        int          w   = int'(addr[4:2]);
        logic [31:0] lineAddr = {addr[31:5], 5'b0};
        int          expStall = 0;
        logic [31:0] expData;
        int          stallCnt = 0;
        bit          done = 1'b0;
        memTxn_t     t;
        if (!(mValid[idx] && mTag[idx] == addr[31:9])) begin
            if (mDirty[idx]) begin
                t.isWrite = 1'b1;
                t.addr    = {mTag[idx], addr[8:5], 5'b0};
                t.data    = mLine[idx];
                t.lat     = wbLat;
                expQ.push_back(t);
                memArr[t.addr] = mLine[idx];
                expStall += wbLat;
            end
            t.isWrite = 1'b0;
            t.addr    = lineAddr;
            t.data    = memLine(lineAddr);
            t.lat     = fillLat;
            expQ.push_back(t);
            expStall += fillLat + 2;
            mLine[idx]  = t.data;
            mTag[idx]   = addr[31:9];
            mValid[idx] = 1'b1;
            mDirty[idx] = 1'b0;
        end
        if (isWrite) begin
            mLine[idx][w*32 +: 32] = data;
            mDirty[idx] = 1'b1;
        end
        expData = isWrite ? 32'h0 : mLine[idx][w*32 +: 32];
        cpu_MemRead_i  = !isWrite;
        cpu_MemWrite_i = isWrite;
        cpu_addr_i     = addr;
        cpu_data_i     = data;
        while (!done) begin
            @(negedge clk_i);
            if (cpu_stall_o) begin
                stallCnt++;
                if (stallCnt > 400) done = 1'b1;
            end else begin
                done = 1'b1;
            end
        end
        lastStall = stallCnt;
        lastData  = cpu_data_o;
        checkOutput("stallCycles", 256'(stallCnt), 256'(expStall));
        checkOutput("loadData", 256'(cpu_data_o), 256'(expData));
        @(posedge clk_i);
        #1;
        cpu_MemRead_i  = 1'b0;
        cpu_MemWrite_i = 1'b0;
    endtask

    // Line memory responder: checks each request against the model and acks after the chosen latency.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            mem_ack_i = 1'b0;
            busy      = 1'b0;
        end else begin
            wasAck    = mem_ack_i;
            mem_ack_i = 1'b0;
            if (wasAck) busy = 1'b0;
            if (!busy && mem_enable_o && respEnable) begin
                checkOutput("memReqExpected", 256'(expQ.size() != 0), 256'(1));
                if (expQ.size() != 0) begin
                    cur = expQ.pop_front();
                end else begin
                    cur.isWrite = mem_write_o;
                    cur.addr    = mem_addr_o;
                    cur.data    = '0;
                    cur.lat     = 1;
                end
                checkOutput("memWrite", 256'(mem_write_o), 256'(cur.isWrite));
                checkOutput("memAddr", 256'(mem_addr_o), 256'(cur.addr));
                if (cur.isWrite) begin
                    checkOutput("memWbData", mem_data_o, cur.data);
                    lastWbAddr = mem_addr_o;
                    lastWbData = mem_data_o;
                end
                busy = 1'b1;
                cnt  = 0;
            end
            if (busy) begin
                cnt++;
                if (cnt >= cur.lat) begin
                    mem_ack_i  = 1'b1;
                    mem_data_i = cur.isWrite ? {8{32'hBAD0BAD0}} : cur.data;
                end
            end else if (!wasAck && !mem_enable_o && spurOn && ($urandom_range(0, 5) == 0)) begin
                mem_ack_i  = 1'b1;
                mem_data_i = {8{$urandom()}};
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [255:0] l;
        logic [31:0]  a;
        rst_i          = 1'b0;
        cpu_MemRead_i  = 1'b0;
        cpu_MemWrite_i = 1'b0;
        cpu_addr_i     = 32'h0;
        cpu_data_i     = 32'h0;
        mem_ack_i      = 1'b0;
        mem_data_i     = '0;
        resetModel();
        l = memLine(32'h40);
        l[31:0]  = 32'hDEADBEEF;
        l[63:32] = 32'h11111111;
        memArr[32'h40] = l;

        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        checkOutput("resetStall", 256'(cpu_stall_o), 256'(0));
        checkOutput("resetMemEnable", 256'(mem_enable_o), 256'(0));
        checkOutput("resetMemWrite", 256'(mem_write_o), 256'(0));
        checkOutput("resetMemAddr", 256'(mem_addr_o), 256'(0));
        checkOutput("resetData", 256'(cpu_data_o), 256'(0));
        @(posedge clk_i);
        #1;

        applyStimulus(1'b0, 32'h0000_0040, 32'h0, 10, 1);
        checkOutput("coldMissStall", 256'(lastStall), 256'(12));
        checkOutput("coldMissData", 256'(lastData), 256'(32'hDEADBEEF));
        applyStimulus(1'b0, 32'h0000_0044, 32'h0, 1, 1);
        checkOutput("readHitStall", 256'(lastStall), 256'(0));
        checkOutput("readHitData", 256'(lastData), 256'(32'h11111111));

        applyStimulus(1'b1, 32'h0000_0040, 32'h12345678, 1, 1);
        checkOutput("writeHitStall", 256'(lastStall), 256'(0));
        applyStimulus(1'b0, 32'h0000_0240, 32'h0, 4, 3);
        checkOutput("dirtyMissStall", 256'(lastStall), 256'(9));
        checkOutput("wbAddr", 256'(lastWbAddr), 256'(32'h40));
        checkOutput("wbWord0", 256'(lastWbData[31:0]), 256'(32'h12345678));

        applyStimulus(1'b1, 32'h0000_1000, 32'hA5A5A5A5, 2, 1);
        checkOutput("writeMissStall", 256'(lastStall), 256'(4));
        applyStimulus(1'b0, 32'h0000_1000, 32'h0, 1, 1);
        checkOutput("mergedWord", 256'(lastData), 256'(32'hA5A5A5A5));
        applyStimulus(1'b0, 32'h0000_1004, 32'h0, 1, 1);
        checkOutput("fillNeighbour", 256'(lastData), 256'(32'hC0DE1004));

        applyStimulus(1'b0, 32'h0000_0060, 32'h0, 1, 1);
        checkOutput("fastAckStall", 256'(lastStall), 256'(3));
        spurOn = 1'b1;
        repeat (12) @(posedge clk_i);
        #1;
        spurOn = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        checkOutput("spuriousNoEnable", 256'(mem_enable_o), 256'(0));
        applyStimulus(1'b0, 32'h0000_0060, 32'h0, 1, 1);
        checkOutput("spuriousHitStall", 256'(lastStall), 256'(0));

        respEnable     = 1'b0;
        cpu_MemRead_i  = 1'b1;
        cpu_addr_i     = 32'h0000_00A0;
        repeat (3) @(negedge clk_i);
        checkOutput("midMissEnable", 256'(mem_enable_o), 256'(1));
        checkOutput("midMissAddr", 256'(mem_addr_o), 256'(32'hA0));
        #1;
        rst_i = 1'b0;
        #1;
        checkOutput("rstMemEnable", 256'(mem_enable_o), 256'(0));
        checkOutput("rstMemAddr", 256'(mem_addr_o), 256'(0));
        cpu_MemRead_i = 1'b0;
        @(negedge clk_i);
        #1;
        rst_i = 1'b1;
        resetModel();
        respEnable = 1'b1;
        @(posedge clk_i);
        #1;
        applyStimulus(1'b0, 32'h0000_0044, 32'h0, 2, 1);
        checkOutput("postResetMissStall", 256'(lastStall), 256'(4));
        checkOutput("postResetData", 256'(lastData), 256'(32'h11111111));

        spurOn = 1'b1;
        for (int i = 0; i < 300; i++) begin
            a = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 15)) << 5)
              | (32'($urandom_range(0, 7)) << 2);
            applyStimulus(1'($urandom_range(0, 1)), a, $urandom(),
                          int'($urandom_range(1, 5)), int'($urandom_range(1, 5)));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk_i);
                #1;
            end
        end
        spurOn = 1'b0;
        repeat (3) @(posedge clk_i);
        checkOutput("queueDrained", 256'(expQ.size()), 256'(0));

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
